// File: rtl/hack_bus_arbiter_if.sv
// Shared Hack RAM bus: two requester ports in, one granted memory port out.
interface hack_bus_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              we0;
  logic              we1;
  logic              gnt0;
  logic              gnt1;
  logic              sel;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;

  modport master (
    output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
    input  gnt0, gnt1, sel, busy, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
    output gnt0, gnt1, sel, busy, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/hack_bus_arbiter.sv
// Two-requester round-robin arbiter with bounded hold time, driving the
// shared memory port through a per-bit select mux.
module hack_bus_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = 8
) (
  input logic                 clk,
  input logic                 reset,
  hack_bus_arbiter_if.slave   bus
);

  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          sel_q, sel_d;
  logic [HW-1:0] hold_q, hold_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    hold_d  = hold_q;

    case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          state_d = last_q ? G0 : G1;
        end else if (bus.req0) begin
          state_d = G0;
        end else if (bus.req1) begin
          state_d = G1;
        end
      end
      G0: begin
        // Release and preempt both hand over when the other side waits.
        if (!bus.req0 || (bus.req1 && hold_q == HOLD_LAST)) begin
          state_d = bus.req1 ? G1 : IDLE;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end
      end
      G1: begin
        if (!bus.req1 || (bus.req0 && hold_q == HOLD_LAST)) begin
          state_d = bus.req0 ? G0 : IDLE;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q && state_d == G0) begin
      sel_d  = 1'b0;
      last_d = 1'b0;
      hold_d = '0;
    end else if (state_d != state_q && state_d == G1) begin
      sel_d  = 1'b1;
      last_d = 1'b1;
      hold_d = '0;
    end
  end

  assign bus.gnt0   = (state_q == G0);
  assign bus.gnt1   = (state_q == G1);
  assign bus.sel    = sel_q;
  assign bus.busy   = bus.gnt0 | bus.gnt1;
  assign bus.mem_we = (bus.gnt0 & bus.we0) | (bus.gnt1 & bus.we1);

  // hMux16-style datapath: one 2:1 mux per bit, steered only by registered sel.
  generate
    for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_addr_mux
      assign bus.mem_addr[gi] = sel_q ? bus.addr1[gi] : bus.addr0[gi];
    end
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_data_mux
      assign bus.mem_wdata[gi] = sel_q ? bus.wdata1[gi] : bus.wdata0[gi];
    end
  endgenerate

endmodule

// File: tb/tb_hack_bus_arbiter.sv
// Directed bench for hack_bus_arbiter: reset, single grant, tie-break,
// hand-over without bubble, hold-limit preemption and reset mid-grant.
module tb_hack_bus_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  hack_bus_arbiter_if #(.ADDR_W(15), .DATA_W(16)) bus ();

  hack_bus_arbiter #(.ADDR_W(15), .DATA_W(16), .MAX_HOLD(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0   = 1'b0;
    bus.req1   = 1'b0;
    bus.addr0  = 15'h1234;
    bus.addr1  = 15'h0555;
    bus.wdata0 = 16'hA5A5;
    bus.wdata1 = 16'h5A5A;
    bus.we0    = 1'b0;
    bus.we1    = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_gnt gnt0=%b gnt1=%b expected 0 0", bus.gnt0, bus.gnt1);
    end
    checks++;
    if (bus.sel !== 1'b0 || bus.busy !== 1'b0 || bus.mem_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_sel_busy_we sel=%b busy=%b mem_we=%b expected 0 0 0",
               bus.sel, bus.busy, bus.mem_we);
    end
    checks++;
    if (bus.mem_addr !== 15'h1234 || bus.mem_wdata !== 16'hA5A5) begin
      failures++;
      $display("FAIL reset_mux mem_addr=%h mem_wdata=%h expected 1234 a5a5",
               bus.mem_addr, bus.mem_wdata);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset busy=%b expected 0", bus.busy);
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_single();
    bus.req1  = 1'b1;
    bus.addr1 = 15'h4000;
    bus.wdata1 = 16'hFFFF;
    bus.we1   = 1'b1;
    tick();
    checks++;
    if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0 || bus.sel !== 1'b1) begin
      failures++;
      $display("FAIL single_grant gnt0=%b gnt1=%b sel=%b expected 0 1 1",
               bus.gnt0, bus.gnt1, bus.sel);
    end
    checks++;
    if (bus.mem_addr !== 15'h4000 || bus.mem_wdata !== 16'hFFFF || bus.mem_we !== 1'b1) begin
      failures++;
      $display("FAIL single_mux mem_addr=%h mem_wdata=%h mem_we=%b expected 4000 ffff 1",
               bus.mem_addr, bus.mem_wdata, bus.mem_we);
    end
    bus.req1 = 1'b0;
    tick();
    checks++;
    if (bus.gnt1 !== 1'b0 || bus.busy !== 1'b0 || bus.mem_we !== 1'b0 || bus.sel !== 1'b1) begin
      failures++;
      $display("FAIL single_release gnt1=%b busy=%b mem_we=%b sel=%b expected 0 0 0 1",
               bus.gnt1, bus.busy, bus.mem_we, bus.sel);
    end
    bus.we1 = 1'b0;
    $display("test_single done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_simultaneous();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.we0  = 1'b0;
    bus.we1  = 1'b1;
    tick();
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || bus.sel !== 1'b0) begin
      failures++;
      $display("FAIL tie_first gnt0=%b gnt1=%b sel=%b expected 1 0 0",
               bus.gnt0, bus.gnt1, bus.sel);
    end
    checks++;
    if (bus.mem_we !== 1'b0) begin
      failures++;
      $display("FAIL we_needs_grant mem_we=%b expected 0", bus.mem_we);
    end
    bus.req0 = 1'b0;
    tick();
    checks++;
    if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0 || bus.sel !== 1'b1 || bus.mem_we !== 1'b1) begin
      failures++;
      $display("FAIL handover_no_bubble gnt0=%b gnt1=%b sel=%b mem_we=%b expected 0 1 1 1",
               bus.gnt0, bus.gnt1, bus.sel, bus.mem_we);
    end
    bus.req1 = 1'b0;
    bus.we1  = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL tie_idle busy=%b expected 0", bus.busy);
    end
    $display("test_simultaneous done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_preempt();
    int run;
    bus.req0 = 1'b1;
    tick();
    run = (bus.gnt0 === 1'b1) ? 1 : 0;
    bus.req1 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus.gnt0 === 1'b1) run++;
    end
    checks++;
    if (run !== 8) begin
      failures++;
      $display("FAIL preempt_hold gnt0_cycles=%0d expected 8", run);
    end
    tick();
    checks++;
    if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0 || bus.sel !== 1'b1) begin
      failures++;
      $display("FAIL preempt_switch gnt0=%b gnt1=%b sel=%b expected 0 1 1",
               bus.gnt0, bus.gnt1, bus.sel);
    end
    bus.req1 = 1'b0;
    tick();
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || bus.sel !== 1'b0) begin
      failures++;
      $display("FAIL preempt_return gnt0=%b gnt1=%b sel=%b expected 1 0 0",
               bus.gnt0, bus.gnt1, bus.sel);
    end
    bus.req0 = 1'b0;
    tick();
    $display("test_preempt done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_uncontested();
    int run;
    run = 0;
    bus.req0 = 1'b1;
    bus.we0  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.gnt0 === 1'b1 && bus.mem_we === 1'b1) run++;
    end
    checks++;
    if (run !== 20) begin
      failures++;
      $display("FAIL uncontested gnt0_cycles=%0d expected 20", run);
    end
    bus.req0 = 1'b0;
    bus.we0  = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_we !== 1'b0) begin
      failures++;
      $display("FAIL uncontested_release busy=%b mem_we=%b expected 0 0", bus.busy, bus.mem_we);
    end
    $display("test_uncontested done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_mid();
    bus.req1 = 1'b1;
    bus.we1  = 1'b1;
    tick();
    checks++;
    if (bus.gnt1 !== 1'b1 || bus.mem_we !== 1'b1) begin
      failures++;
      $display("FAIL mid_setup gnt1=%b mem_we=%b expected 1 1", bus.gnt1, bus.mem_we);
    end
    reset    = 1'b1;
    bus.req0 = 1'b1;
    tick();
    checks++;
    if (bus.gnt1 !== 1'b0 || bus.gnt0 !== 1'b0 || bus.mem_we !== 1'b0 || bus.sel !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset gnt0=%b gnt1=%b mem_we=%b sel=%b expected 0 0 0 0",
               bus.gnt0, bus.gnt1, bus.mem_we, bus.sel);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
      failures++;
      $display("FAIL mid_regrant gnt0=%b gnt1=%b expected 1 0", bus.gnt0, bus.gnt1);
    end
    idle_inputs();
    tick();
    tick();
    $display("test_reset_mid done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle_inputs();
    #2;
    test_reset();
    test_single();
    test_simultaneous();
    test_preempt();
    test_uncontested();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
